// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store stage with req/ack word bus
// Optional misaligned-access trapping is enabled by defining MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_load,
  input  logic        start_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic        is_load_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt;

  logic        start_any;
  logic        f3_illegal;
  logic        trap;
  logic        timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  assign start_any   = start_load | start_store;
  assign f3_illegal  = start_load ? (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)
                                  : (funct3 >= 3'd3);
`ifdef MISALIGN_TRAP_EN
  assign trap = (funct3[1:0] == 2'b01 && addr[0]) ||
                (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif
  // An ack arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST) && !mem_ack;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_be    = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (off_q)
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      2'd3:    rd_byte = mem_rdata[31:24];
      default: ;
    endcase
    rd_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    case (f3_q[1:0])
      2'b00:   load_ext = f3_q[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = f3_q[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start_any) state_next = (f3_illegal || trap) ? S_DONE : S_ACCESS;
      S_ACCESS: if (mem_ack || timeout_hit) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      is_load_q <= 1'b0;
      f3_q      <= 3'b0;
      off_q     <= 2'b0;
      cnt       <= 8'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      load_data <= 32'b0;
      bus_err   <= 1'b0;
      misalign  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'b0;
      mem_be    <= 4'b0;
      mem_wdata <= 32'b0;
    end else begin
      state    <= state_next;
      busy     <= (state_next != S_IDLE);
      mem_req  <= (state_next == S_ACCESS);
      done     <= (state_next == S_DONE);
      bus_err  <= 1'b0;
      misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_any) begin
            is_load_q <= start_load;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            cnt       <= 8'b0;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_we    <= !start_load;
            mem_be    <= start_load ? 4'b1111 : st_be;
            mem_wdata <= start_load ? 32'b0 : st_wdata;
            if (f3_illegal) begin
              bus_err   <= 1'b1;
              load_data <= 32'b0;
            end else if (trap) begin
              misalign  <= 1'b1;
              load_data <= 32'b0;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            load_data <= is_load_q ? load_ext : 32'b0;
          end else if (timeout_hit) begin
            bus_err   <= 1'b1;
            load_data <= 32'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
